// File: rtl/sgpr_retire_sequencer_pkg.sv
// Shared types and constants for the SGPR retire broadcast path.
// Optional build macro SGPR_RETIRE_PERF_EN is consumed by the top level.
package sgpr_retire_sequencer_pkg;

  localparam int unsigned SGPR_ADDR_W    = 9;
  localparam int unsigned WFID_W         = 6;
  localparam int unsigned RETIRE_MASK_W  = 4;
  localparam int unsigned MAX_LSU_DWORDS = 16;
  localparam int unsigned CNT_W          = $clog2(MAX_LSU_DWORDS) + 1;
  localparam int unsigned PERF_CNT_W     = 16;

  typedef enum logic [0:0] {
    SGPR_RETIRE_IDLE  = 1'b0,
    SGPR_RETIRE_SPLIT = 1'b1
  } retire_state_e;

  typedef struct packed {
    logic [WFID_W-1:0]        wfid;
    logic [SGPR_ADDR_W-1:0]   addr;
    logic [RETIRE_MASK_W-1:0] mask;
  } retire_beat_t;

  // Dword mask for the chunk starting at the current base with 'remaining' dwords left.
  function automatic logic [RETIRE_MASK_W-1:0] chunk_mask(input logic [CNT_W-1:0] remaining);
    if (remaining >= CNT_W'(RETIRE_MASK_W)) begin
      return '1;
    end
    return RETIRE_MASK_W'((32'd1 << remaining) - 32'd1);
  endfunction

endpackage

// File: rtl/sgpr_retire_sequencer_if.sv
// SALU/LSU retire inputs and the merged retire beat stream.
// master drives the retire events; slave is the sequencer.
interface sgpr_retire_sequencer_if;
  import sgpr_retire_sequencer_pkg::*;

  logic                     salu_retire_valid;
  logic [WFID_W-1:0]        salu_retire_wfid;
  logic [SGPR_ADDR_W-1:0]   salu_retire_addr;
  logic [1:0]               salu_retire_mask;

  logic                     lsu_retire_valid;
  logic                     lsu_retire_ready;
  logic [WFID_W-1:0]        lsu_retire_wfid;
  logic [SGPR_ADDR_W-1:0]   lsu_retire_addr;
  logic [CNT_W-1:0]         lsu_retire_count;

  logic                     retire_valid;
  logic [WFID_W-1:0]        retire_wfid;
  logic [SGPR_ADDR_W-1:0]   retire_addr;
  logic [RETIRE_MASK_W-1:0] retire_mask;

  modport master (
    output salu_retire_valid, salu_retire_wfid, salu_retire_addr, salu_retire_mask,
    output lsu_retire_valid, lsu_retire_wfid, lsu_retire_addr, lsu_retire_count,
    input  lsu_retire_ready,
    input  retire_valid, retire_wfid, retire_addr, retire_mask
  );

  modport slave (
    input  salu_retire_valid, salu_retire_wfid, salu_retire_addr, salu_retire_mask,
    input  lsu_retire_valid, lsu_retire_wfid, lsu_retire_addr, lsu_retire_count,
    output lsu_retire_ready,
    output retire_valid, retire_wfid, retire_addr, retire_mask
  );

endinterface

// File: rtl/sgpr_retire_sequencer_splitter.sv
// LSU scalar-load splitter: accepts one load at a time and walks it out as
// 4-dword chunks; a SALU event in the same cycle stalls the walk.
module sgpr_retire_splitter
  import sgpr_retire_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_valid,
  input  logic [WFID_W-1:0]      lsu_wfid,
  input  logic [SGPR_ADDR_W-1:0] lsu_addr,
  input  logic [CNT_W-1:0]       lsu_count,
  input  logic                   salu_stall,
  output logic                   lsu_ready_c,
  output logic                   beat_valid_c,
  output retire_beat_t           beat_c
);

  retire_state_e          state_q, state_d;
  logic [WFID_W-1:0]      wfid_q, wfid_d;
  logic [SGPR_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       rem_q, rem_d;

  // State and chunk registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SGPR_RETIRE_IDLE;
      wfid_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wfid_q  <= wfid_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next state, chunk advance and the candidate LSU beat
  always_comb begin
    state_d      = state_q;
    wfid_d       = wfid_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    lsu_ready_c  = (state_q == SGPR_RETIRE_IDLE);
    beat_valid_c = 1'b0;
    beat_c.wfid  = wfid_q;
    beat_c.addr  = addr_q;
    beat_c.mask  = chunk_mask(rem_q);

    unique case (state_q)
      SGPR_RETIRE_IDLE: begin
        // A zero-count request completes the handshake without leaving IDLE.
        if (lsu_valid && (lsu_count != '0)) begin
          state_d = SGPR_RETIRE_SPLIT;
          wfid_d  = lsu_wfid;
          addr_d  = lsu_addr;
          rem_d   = lsu_count;
        end
      end
      SGPR_RETIRE_SPLIT: begin
        if (!salu_stall) begin
          beat_valid_c = 1'b1;
          addr_d       = addr_q + SGPR_ADDR_W'(RETIRE_MASK_W);
          if (rem_q <= CNT_W'(RETIRE_MASK_W)) begin
            state_d = SGPR_RETIRE_IDLE;
            rem_d   = '0;
          end else begin
            rem_d   = rem_q - CNT_W'(RETIRE_MASK_W);
          end
        end
      end
      default: state_d = SGPR_RETIRE_IDLE;
    endcase
  end

endmodule

// File: rtl/sgpr_retire_sequencer.sv
// Merges SALU and LSU SGPR write completions into one registered retire stream.
// Define SGPR_RETIRE_PERF_EN to add perf_lsu_stall_cnt (SALU pre-emption cycles).
module sgpr_retire_sequencer
  import sgpr_retire_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
`ifdef SGPR_RETIRE_PERF_EN
  output logic [PERF_CNT_W-1:0] perf_lsu_stall_cnt,
`endif
  sgpr_retire_sequencer_if.slave bus
);

  logic         lsu_ready_c;
  logic         lsu_beat_valid_c;
  retire_beat_t lsu_beat_c;
  retire_beat_t salu_beat_c;
  logic         retire_valid_q;
  retire_beat_t retire_q;

  sgpr_retire_splitter u_splitter (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid    (bus.lsu_retire_valid),
    .lsu_wfid     (bus.lsu_retire_wfid),
    .lsu_addr     (bus.lsu_retire_addr),
    .lsu_count    (bus.lsu_retire_count),
    .salu_stall   (bus.salu_retire_valid),
    .lsu_ready_c  (lsu_ready_c),
    .beat_valid_c (lsu_beat_valid_c),
    .beat_c       (lsu_beat_c)
  );

  assign salu_beat_c.wfid = bus.salu_retire_wfid;
  assign salu_beat_c.addr = bus.salu_retire_addr;
  assign salu_beat_c.mask = {2'b00, bus.salu_retire_mask};

  // Output register; SALU always takes the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_valid_q <= 1'b0;
      retire_q       <= '0;
    end else if (bus.salu_retire_valid) begin
      retire_valid_q <= 1'b1;
      retire_q       <= salu_beat_c;
    end else if (lsu_beat_valid_c) begin
      retire_valid_q <= 1'b1;
      retire_q       <= lsu_beat_c;
    end else begin
      retire_valid_q <= 1'b0;
    end
  end

  assign bus.lsu_retire_ready = lsu_ready_c;
  assign bus.retire_valid     = retire_valid_q;
  assign bus.retire_wfid      = retire_q.wfid;
  assign bus.retire_addr      = retire_q.addr;
  assign bus.retire_mask      = retire_q.mask;

`ifdef SGPR_RETIRE_PERF_EN
  // Saturating count of SPLIT cycles lost to SALU priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lsu_stall_cnt <= '0;
    end else if (bus.salu_retire_valid && !lsu_ready_c && (perf_lsu_stall_cnt != '1)) begin
      perf_lsu_stall_cnt <= perf_lsu_stall_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sgpr_retire_sequencer.sv
// Bench for sgpr_retire_sequencer: directed scenarios plus random traffic
// against a queue-based model of the expected beat stream.
module tb_sgpr_retire_sequencer;
  import sgpr_retire_sequencer_pkg::*;

  typedef struct {
    logic [WFID_W-1:0]      wfid;
    logic [SGPR_ADDR_W-1:0] addr;
    logic [3:0]             mask;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sgpr_retire_sequencer_if bus();

`ifdef SGPR_RETIRE_PERF_EN
  logic [15:0] perf_cnt;
  int          perf_model;
`endif

  sgpr_retire_sequencer dut (
    .clk                (clk),
    .rst                (rst),
`ifdef SGPR_RETIRE_PERF_EN
    .perf_lsu_stall_cnt (perf_cnt),
`endif
    .bus                (bus)
  );

  int    total = 0;
  int    bad   = 0;
  beat_t pend[$];
  logic  exp_valid;
  beat_t exp_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_model_outputs();
    chk("retire_valid", 32'(bus.retire_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("retire_wfid", 32'(bus.retire_wfid), 32'(exp_beat.wfid));
      chk("retire_addr", 32'(bus.retire_addr), 32'(exp_beat.addr));
      chk("retire_mask", 32'(bus.retire_mask), 32'(exp_beat.mask));
    end
`ifdef SGPR_RETIRE_PERF_EN
    chk("perf_lsu_stall_cnt", 32'(perf_cnt), 32'(perf_model));
`endif
  endtask

  // One clock: check the previous edge's result, drive inputs, advance the model.
  task automatic cycle(input logic sv, input int swf, input int sa, input int sm,
                       input logic lv, input int lwf, input int la, input int lc);
    bit busy;
    int n;
    @(negedge clk);
    check_model_outputs();
    bus.salu_retire_valid = sv;
    bus.salu_retire_wfid  = WFID_W'(swf);
    bus.salu_retire_addr  = SGPR_ADDR_W'(sa);
    bus.salu_retire_mask  = 2'(sm);
    bus.lsu_retire_valid  = lv;
    bus.lsu_retire_wfid   = WFID_W'(lwf);
    bus.lsu_retire_addr   = SGPR_ADDR_W'(la);
    bus.lsu_retire_count  = CNT_W'(lc);
    busy = (pend.size() != 0);
    chk("lsu_retire_ready", 32'(bus.lsu_retire_ready), 32'(!busy));
    if (sv) begin
      exp_valid     = 1'b1;
      exp_beat.wfid = WFID_W'(swf);
      exp_beat.addr = SGPR_ADDR_W'(sa);
      exp_beat.mask = 4'(sm & 3);
`ifdef SGPR_RETIRE_PERF_EN
      if (busy && perf_model < 65535) perf_model++;
`endif
    end else if (busy) begin
      exp_valid = 1'b1;
      exp_beat  = pend.pop_front();
    end else begin
      exp_valid = 1'b0;
    end
    if (!busy && lv && lc != 0) begin
      n = (lc + 3) / 4;
      for (int i = 0; i < n; i++) begin
        beat_t b;
        int left;
        left   = lc - 4 * i;
        b.wfid = WFID_W'(lwf);
        b.addr = SGPR_ADDR_W'((la + 4 * i) % 512);
        b.mask = (left >= 4) ? 4'hF : 4'((1 << left) - 1);
        pend.push_back(b);
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic lit_beat(input int a, input int m);
    chk("lit_valid", 32'(bus.retire_valid), 32'd1);
    chk("lit_addr", 32'(bus.retire_addr), 32'(a));
    chk("lit_mask", 32'(bus.retire_mask), 32'(m));
  endtask

  task automatic lit_none();
    chk("lit_no_beat", 32'(bus.retire_valid), 32'd0);
  endtask

  task automatic lit_ready(input int r);
    chk("lit_ready", 32'(bus.lsu_retire_ready), 32'(r));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.salu_retire_valid = 1'b0;
    bus.lsu_retire_valid  = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.retire_valid), 32'd0);
    chk("rst_wfid", 32'(bus.retire_wfid), 32'd0);
    chk("rst_addr", 32'(bus.retire_addr), 32'd0);
    chk("rst_mask", 32'(bus.retire_mask), 32'd0);
    chk("rst_ready", 32'(bus.lsu_retire_ready), 32'd1);
    pend.delete();
    exp_valid = 1'b0;
    exp_beat  = '{default: '0};
`ifdef SGPR_RETIRE_PERF_EN
    perf_model = 0;
`endif
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.salu_retire_valid = 1'b0;
    bus.salu_retire_wfid  = '0;
    bus.salu_retire_addr  = '0;
    bus.salu_retire_mask  = '0;
    bus.lsu_retire_valid  = 1'b0;
    bus.lsu_retire_wfid   = '0;
    bus.lsu_retire_addr   = '0;
    bus.lsu_retire_count  = '0;
    do_reset();
    repeat (3) idle();
    lit_none();
    lit_ready(1);

    // SALU 64-bit write
    cycle(1'b1, 5, 10, 3, 1'b0, 0, 0, 0);
    idle(); lit_beat(10, 4'b0011);
    chk("lit_salu_wfid", 32'(bus.retire_wfid), 32'd5);
    idle(); lit_none();

    // LSU count=10 split into three beats
    cycle(1'b0, 0, 0, 0, 1'b1, 3, 20, 10);
    idle(); lit_none(); lit_ready(0);
    idle(); lit_beat(20, 4'hF);
    chk("lit_lsu_wfid", 32'(bus.retire_wfid), 32'd3);
    idle(); lit_beat(24, 4'hF);
    idle(); lit_beat(28, 4'b0011); lit_ready(1);
    idle(); lit_none();

    // SALU pre-empts first SPLIT cycle
    do_reset();
    cycle(1'b0, 0, 0, 0, 1'b1, 7, 20, 8);
    cycle(1'b1, 1, 2, 1, 1'b0, 0, 0, 0);
    idle(); lit_beat(2, 4'b0001);
    idle(); lit_beat(20, 4'hF);
    idle(); lit_beat(24, 4'hF);
`ifdef SGPR_RETIRE_PERF_EN
    chk("lit_perf", 32'(perf_cnt), 32'd1);
`endif
    idle(); lit_none();

    // Address wrap
    cycle(1'b0, 0, 0, 0, 1'b1, 9, 510, 5);
    idle();
    idle(); lit_beat(510, 4'hF);
    idle(); lit_beat(2, 4'b0001);
    idle(); lit_none();

    // Reset mid-split, then immediate accept and a zero-count request
    cycle(1'b0, 0, 0, 0, 1'b1, 2, 64, 16);
    idle();
    idle(); lit_beat(64, 4'hF);
    do_reset();
    lit_ready(1);
    cycle(1'b0, 0, 0, 0, 1'b1, 4, 100, 4);
    idle(); lit_none();
    idle(); lit_beat(100, 4'hF);
    idle(); lit_none();
    cycle(1'b0, 0, 0, 0, 1'b1, 4, 200, 0);
    idle(); lit_none(); lit_ready(1);
    idle(); lit_none();

    // Random mixed traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 9) < 3), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 511)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 511)), int'($urandom_range(0, 16)));
      end
    end
    repeat (8) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sgpr_retire_sequencer.md
Name: sgpr_retire_sequencer

Overview:
- Producer side of the SGPR retire broadcast consumed by the issue-stage scoreboard comparators.
- Merges SGPR write-completion events from the SALU (1–2 dwords) and LSU scalar loads (1–16 dwords) into a single registered stream of (wfid, base address, 4-bit dword mask) retire beats.
- LSU loads wider than 4 dwords are split into successive aligned-to-base 4-dword beats.
- Sits between the SALU/LSU retire outputs and the issue-stage scoreboard.

Parameters:
- SGPR_ADDR_W, 9, SGPR address width; equals `SGPR_ADDR_LENGTH.
- WFID_W, 6, wavefront id width.
- CNT_W, 5, LSU dword-count width; legal counts are 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- salu_retire_valid  in  1  SALU SGPR write completed this cycle. No back-pressure.
- salu_retire_wfid  in  WFID_W  wavefront of the SALU write.
- salu_retire_addr  in  SGPR_ADDR_W  first SGPR written by the SALU.
- salu_retire_mask  in  2  01 = 32-bit write, 11 = 64-bit write.
- lsu_retire_valid  in  1  LSU scalar-load retire request.
- lsu_retire_ready  out  1  request accepted when valid & ready.
- lsu_retire_wfid  in  WFID_W  wavefront of the LSU load.
- lsu_retire_addr  in  SGPR_ADDR_W  base SGPR of the LSU load.
- lsu_retire_count  in  CNT_W  number of dwords, 1..16.
- retire_valid  out  1  retire beat valid.
- retire_wfid  out  WFID_W  wavefront of the beat.
- retire_addr  out  SGPR_ADDR_W  base SGPR of the beat.
- retire_mask  out  4  bit i set means SGPR retire_addr+i retired.

Behaviour:
- Reset (async, rst=1):
  - retire_valid=0, retire_wfid=0, retire_addr=0, retire_mask=0.
  - FSM goes to IDLE; chunk registers are cleared.
  - An in-flight LSU split is discarded with no further beats.
- All outputs except lsu_retire_ready are registered.
- Latency: one cycle from the winning source to retire_*.
- Output has no back-pressure; retire_valid is high for exactly one cycle per beat.
- Priority: SALU always wins. A SALU event in cycle N produces a beat in cycle N+1 with mask {2'b00, salu_retire_mask}. SALU is never delayed.
- lsu_retire_ready = (state==IDLE). It is combinational and high during and after reset.
- FSM states:
  - IDLE → SPLIT on lsu_retire_valid & lsu_retire_ready & count≠0. Latches wfid, cur_addr=addr, remaining=count. No LSU beat is emitted in the accept cycle.
  - A request with count=0 is consumed (handshake completes), produces no beat, and the FSM stays in IDLE.
  - SPLIT, no SALU event: emit beat {wfid, cur_addr, mask}.
    - mask = 4'b1111 if remaining≥4, else (1<<remaining)-1.
    - cur_addr += 4, modulo 2^SGPR_ADDR_W (wraps 511→3).
    - remaining -= 4.
    - If remaining≤4 before the update, go to IDLE.
  - SPLIT, SALU event: the SALU beat is emitted. LSU state holds unchanged (stall).
- Beat count for an LSU request = ceil(count/4).
- Back-to-back LSU requests: the next request is accepted in the cycle after the FSM returns to IDLE. Minimum gap is 1 cycle.
- Simultaneous SALU event and LSU accept in IDLE: both proceed. The SALU beat is emitted and the LSU request is latched.
- salu_retire_mask=00 with valid=1: a beat is still emitted with mask 0000. This is harmless to the scoreboard.

Optional Feature:
- Macro: SGPR_RETIRE_PERF_EN.
- Defined:
  - Adds output perf_lsu_stall_cnt, 16 bits.
  - Counts cycles spent in SPLIT while pre-empted by the SALU.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counter are absent. Functional behaviour is identical in both builds.

Decomposition:
- Shared package / `define header (alongside issue_definitions):
  - SGPR_RETIRE_IDLE and SGPR_RETIRE_SPLIT state encodings.
  - RETIRE_MASK_W=4.
  - MAX_LSU_DWORDS=16.
- One natural sub-module, sgpr_retire_splitter: the LSU FSM plus chunk-mask generation. The top level handles SALU priority and the output register.

Test Plan:
- Reset released; idle inputs → retire_valid=0 every cycle; lsu_retire_ready=1.
- SALU valid, wfid=5, addr=10, mask=11 at cycle N → cycle N+1: retire_valid=1, wfid=5, addr=10, mask=0011; retire_valid=0 at N+2.
- LSU wfid=3, addr=20, count=10 → 3 consecutive beats: (20,1111), (24,1111), (28,0011). ready is low for 3 cycles, then high.
- LSU addr=20, count=8, with a SALU event (addr=2, mask=01) on the first SPLIT cycle → beats in order (2,0001), (20,1111), (24,1111). With PERF_EN, perf_lsu_stall_cnt=1.
- LSU addr=510, count=5 → beats (510,1111), (2,0001). Address wraps.
- rst pulsed mid-split of count=16 after 1 beat → no further beats; next LSU request is accepted immediately after reset; count=0 request → no beat, ready stays 1.
